// File: rtl/des_dec_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : des_dec_key_sched
// Brief    : Sequential DES decrypt subkey generator, emits K16 down to K1
//            through a valid/ready handshake from a single C/D register pair.
// Revision : 1.0 - initial release
// ============================================================================
module des_dec_key_sched #(
    parameter int NROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  round_num,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] LAST_IDX = 4'(NROUNDS - 1);

    // FIPS 46-3 tables, 1-based bit numbers with bit 1 as the MSB
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GEN  = 1'b1
    } state_t;

    function automatic logic [55:0] pc1_perm(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55-i] = k[64-PC1[i]];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[47-i] = cd[56-PC2[i]];
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_half_q, c_half_d;
    logic [27:0] d_half_q, d_half_d;
    logic [3:0]  idx_q, idx_d;
    logic        subkey_valid_q, subkey_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        w_handshake;
    logic        w_rot_one;
    logic [55:0] w_pc1;

    assign w_handshake = subkey_valid_q & subkey_ready;
    assign w_pc1       = pc1_perm(key_in);

    // The rotation ahead of output idx+1 is single for outputs 1, 8 and 15
    assign w_rot_one = (idx_q == 4'd0) || (idx_q == 4'd7) || (idx_q == 4'd14);

    always_comb begin
        state_d        = state_q;
        c_half_d       = c_half_q;
        d_half_d       = d_half_q;
        idx_d          = idx_q;
        subkey_valid_d = subkey_valid_q;
        busy_d         = busy_q;
        done_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    c_half_d       = w_pc1[55:28];
                    d_half_d       = w_pc1[27:0];
                    idx_d          = 4'd0;
                    state_d        = ST_GEN;
                    subkey_valid_d = 1'b1;
                    busy_d         = 1'b1;
                end
            end
            ST_GEN: begin
                if (w_handshake) begin
                    if (idx_q == LAST_IDX) begin
                        state_d        = ST_IDLE;
                        subkey_valid_d = 1'b0;
                        busy_d         = 1'b0;
                        done_d         = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        if (w_rot_one) begin
                            c_half_d = {c_half_q[0],   c_half_q[27:1]};
                            d_half_d = {d_half_q[0],   d_half_q[27:1]};
                        end else begin
                            c_half_d = {c_half_q[1:0], c_half_q[27:2]};
                            d_half_d = {d_half_q[1:0], d_half_q[27:2]};
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            c_half_q       <= '0;
            d_half_q       <= '0;
            idx_q          <= '0;
            subkey_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            c_half_q       <= c_half_d;
            d_half_q       <= d_half_d;
            idx_q          <= idx_d;
            subkey_valid_q <= subkey_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign subkey       = pc2_perm({c_half_q, d_half_q});
    assign round_num    = LAST_IDX - idx_q;
    assign subkey_valid = subkey_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_des_dec_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_dec_key_sched
// Brief    : Self-checking bench for des_dec_key_sched against directed
//            vectors and a forward (encrypt-order) key schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_dec_key_sched;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef struct {
        logic [63:0] key;
        logic [47:0] first;
        logic [47:0] last;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] key_in;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic [3:0]  round_num;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [47:0] exp_k [16];
    logic [47:0] got_first;
    logic [47:0] got_last;
    vec_t        vecs [5];

    always #5 clk = ~clk;

    des_dec_key_sched #(.NROUNDS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key_in       (key_in),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .round_num    (round_num),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Forward schedule: exp_k[r] holds K(r+1), built with encrypt left shifts
    task automatic compute_ref(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] k;
        int          sh;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            sh = (r == 0 || r == 1 || r == 8 || r == 15) ? 1 : 2;
            for (int s = 0; s < sh; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) k[47-j] = cd[56-PC2_T[j]];
            exp_k[r] = k;
        end
    endtask

    // Consume the schedule already started; returns at the negedge where done should be high
    task automatic drain(input bit rnd, input int inject);
        int h;
        int cyc;
        bit injected;
        h = 0;
        cyc = 0;
        injected = 1'b0;
        while (h < 16 && cyc < 400) begin
            chk("valid", 64'(subkey_valid), 64'd1);
            chk("busy", 64'(busy), 64'd1);
            chk("done_low", 64'(done), 64'd0);
            chk("subkey", 64'(subkey), 64'(exp_k[15-h]));
            chk("round_num", 64'(round_num), 64'(15 - h));
            if (h == 0)  got_first = subkey;
            if (h == 15) got_last  = subkey;
            if (inject >= 0 && h == inject && !injected) begin
                start = 1'b1;
                injected = 1'b1;
            end else begin
                start = 1'b0;
            end
            subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            key_in = {$urandom, $urandom};
            @(negedge clk);
            if (subkey_ready) h++;
            cyc++;
        end
        start = 1'b0;
        subkey_ready = 1'b0;
        if (h < 16) chk("handshake_timeout", 64'(h), 64'd16);
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_drop", 64'(busy), 64'd0);
        chk("valid_drop", 64'(subkey_valid), 64'd0);
    endtask

    task automatic run_sched(input logic [63:0] key, input bit rnd, input int inject);
        compute_ref(key);
        key_in = key;
        start = 1'b1;
        subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(rnd, inject);
    endtask

    // Ready is held high while nothing is valid to show it has no effect
    task automatic idle_after();
        subkey_ready = 1'b1;
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_valid", 64'(subkey_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("idle_valid2", 64'(subkey_valid), 64'd0);
        subkey_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rk;

        vecs[0] = '{64'h133457799BBCDFF1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
        vecs[1] = '{64'h0000000000000000, 48'h000000000000, 48'h000000000000};
        vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};
        vecs[3] = '{64'h0101010101010101, 48'h000000000000, 48'h000000000000};
        vecs[4] = '{64'hFEFEFEFEFEFEFEFE, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};

        rst_n = 1'b0;
        start = 1'b0;
        subkey_ready = 1'b0;
        key_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(subkey_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_round", 64'(round_num), 64'd15);
        chk("rst_subkey", 64'(subkey), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_start", 64'(subkey_valid), 64'd0);

        for (int i = 0; i < 5; i++) begin
            run_sched(vecs[i].key, 1'b0, -1);
            chk("vec_first_k16", 64'(got_first), 64'(vecs[i].first));
            chk("vec_last_k1", 64'(got_last), 64'(vecs[i].last));
            idle_after();
        end

        // Back-pressure with random ready
        run_sched(64'h133457799BBCDFF1, 1'b1, -1);
        chk("stall_first_k16", 64'(got_first), 64'hCB3D8B0E17F5);
        chk("stall_last_k1", 64'(got_last), 64'h1B02EFFC7072);
        idle_after();

        // Restart attempt at round 10 is ignored; restart in the done cycle is taken
        run_sched(64'h133457799BBCDFF1, 1'b0, 5);
        run_sched(64'h0F1571C947D9E859, 1'b0, -1);
        idle_after();

        // Reset mid-schedule
        compute_ref(64'h133457799BBCDFF1);
        key_in = 64'h133457799BBCDFF1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        subkey_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("pre_rst_round", 64'(round_num), 64'd7);
        subkey_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_valid", 64'(subkey_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_round", 64'(round_num), 64'd15);
        run_sched(64'h133457799BBCDFF1, 1'b0, -1);
        idle_after();

        for (int i = 0; i < 200; i++) begin
            rk = {$urandom, $urandom};
            run_sched(rk, 1'(i % 2), -1);
            idle_after();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/des_dec_key_sched.md
Name: des_dec_key_sched

Overview:
- Sequential DES subkey generator for the decryption direction.
- Takes a 64-bit key and emits the sixteen 48-bit round keys in reverse order (K16 first, K1 last), one per valid/ready handshake.
- Feeds the decrypt datapath, where each subkey is XORed with the expanded R half before the S-box stage.
- Replaces a full 16-entry subkey ROM with one C/D register pair rotated right.

Parameters:
- NROUNDS, 16, number of subkeys per key; fixed to 16 for DES, exposed only for bench sizing.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  request a new schedule; sampled only in IDLE
- key_in  input  64  DES key; DES bit 1 = key_in[63]; parity bits (DES 8,16,…,64) ignored
- subkey_ready  input  1  consumer accepts the current subkey this cycle
- subkey  output  48  current round key; DES bit 1 = subkey[47]
- subkey_valid  output  1  subkey holds a valid round key
- round_num  output  4  DES round of the current subkey, encoded round-1 (15 = K16 … 0 = K1)
- busy  output  1  schedule in progress; start ignored
- done  output  1  one-cycle pulse after K1 is accepted

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, C=D=0, subkey_valid=0, busy=0, done=0, round_num=15, idx=0. subkey = PC-2 of the zero state = 0. Reset is synchronous and overrides everything, including mid-schedule; a partial schedule is discarded.
- States: IDLE, GEN.
- IDLE, start=1 at edge t:
  - {C,D} <= PC-1(key_in): C = 28 bits, D = 28 bits.
  - idx <= 0; state <= GEN.
  - subkey_valid=1 and busy=1 from cycle t+1.
  - Latency start→first subkey = 1 cycle.
- GEN:
  - subkey = PC-2({C,D}), combinational from registered C/D.
  - round_num = 15 - idx.
  - subkey and round_num are held stable while subkey_valid=1 and subkey_ready=0. No drop, no change.
- Handshake (subkey_valid & subkey_ready at an edge) with idx<15:
  - idx <= idx+1.
  - C and D each rotate right by R(idx+1), where R(i) is the right-rotation applied before output i.
  - R(i)=1 for i ∈ {1, 8, 15}; R(i)=2 for all other i in 1..14. This equals the encrypt left-shift of round 17-i.
  - First output needs no rotation: the encrypt shifts total 28, so C16=C0 and D16=D0.
- Handshake with idx=15:
  - state <= IDLE; subkey_valid <= 0; busy <= 0; done <= 1 for exactly one cycle.
  - C/D are not cleared.
- start while busy: ignored, no restart. start in the done cycle is accepted (state is already IDLE); done and the new load coincide.
- key_in is sampled only on start acceptance; later changes have no effect on the schedule in progress.
- Throughput: 16 subkeys in 16 consecutive cycles with subkey_ready held 1. Start-to-done = 17 cycles.
- subkey_ready while subkey_valid=0: no effect.
- Bit numbering, PC-1, PC-2 per FIPS 46-3. Rotation wraps within each 28-bit half only.

Test Plan:
- key_in=64'h133457799BBCDFF1, start pulse, subkey_ready=1 → cycle+1: subkey=48'hCB3D8B0E17F5, round_num=15. 16th subkey = 48'h1B02EFFC7072 with round_num=0. done pulses on the following cycle; busy drops with it.
- Same key, subkey_ready toggled pseudo-randomly → identical 16-value sequence, in order. subkey stable whenever valid&!ready. Exactly 16 handshakes; no duplicates.
- key_in=64'h0 and key_in=64'hFFFFFFFFFFFFFFFF → all 16 subkeys 0 and 48'hFFFFFFFFFFFF respectively. Flipping only parity bits (64'h0101010101010101) → identical output to the all-zero key.
- start reasserted with a different key at round_num=10 → ignored; remaining subkeys match the original key. start in the done cycle → new K16 valid the next cycle.
- rst_n=0 for one cycle at round_num=7 → next cycle: subkey_valid=0, busy=0, done=0, round_num=15. A fresh start then reproduces the full correct sequence.
- Reference-model compare: 200 random keys, each reversed sequence checked against a software encrypt-schedule K1..K16 read backwards.
